// File: rtl/uart_rx_capture_if.sv
// Control and read-back bus between the UART receive capture engine and the sequencer.
// The sequencer drives enable, clear and read address; the engine returns data, count and flags.
interface uart_rx_capture_if #(
  parameter int G_DATA_WIDTH        = 8,
  parameter int G_BUFFER_ADDR_WIDTH = 8
);
  logic                           i_en;
  logic                           i_clr;
  logic [G_BUFFER_ADDR_WIDTH-1:0] i_rd_addr;
  logic [G_DATA_WIDTH-1:0]        o_rd_data;
  logic [G_BUFFER_ADDR_WIDTH:0]   o_wr_cnt;
  logic                           o_rx_done;
  logic                           o_parity_err;
  logic                           o_frame_err;
  logic                           o_overflow;

  modport master (
    output i_en, i_clr, i_rd_addr,
    input  o_rd_data, o_wr_cnt, o_rx_done, o_parity_err, o_frame_err, o_overflow
  );

  modport slave (
    input  i_en, i_clr, i_rd_addr,
    output o_rd_data, o_wr_cnt, o_rx_done, o_parity_err, o_frame_err, o_overflow
  );
endinterface

// File: rtl/uart_rx_capture.sv
// UART receive engine: deserialises frames from the serial line and stores each word
// in a capture buffer that the sequencer reads back, with sticky error flags.
module uart_rx_capture #(
  parameter int G_CLOCK_FREQ        = 20000000,
  parameter int G_BAUDRATE          = 115200,
  parameter int G_DATA_WIDTH        = 8,
  parameter int G_PARITY            = 0,
  parameter int G_STOP_BIT_NUMBER   = 1,
  parameter int G_FIRST_BIT         = 0,
  parameter int G_POLARITY          = 1,
  parameter int G_BUFFER_ADDR_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rx,
  uart_rx_capture_if.slave  bus
);

  localparam int C_BIT_PERIOD  = G_CLOCK_FREQ / G_BAUDRATE;
  localparam int C_HALF_PERIOD = C_BIT_PERIOD / 2;
  localparam int C_CNT_W       = $clog2(C_BIT_PERIOD + 1);
  localparam int C_BITS_W      = $clog2(G_DATA_WIDTH + 1);
  localparam int C_DEPTH       = 2 ** G_BUFFER_ADDR_WIDTH;

  localparam logic [C_CNT_W-1:0]           C_CNT_ZERO  = C_CNT_W'(0);
  localparam logic [C_CNT_W-1:0]           C_CNT_ONE   = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0]           C_BIT_LAST  = C_CNT_W'(C_BIT_PERIOD - 1);
  localparam logic [C_CNT_W-1:0]           C_HALF_LAST = C_CNT_W'(C_HALF_PERIOD - 1);
  localparam logic [C_BITS_W-1:0]          C_BITS_ZERO = C_BITS_W'(0);
  localparam logic [C_BITS_W-1:0]          C_BITS_ONE  = C_BITS_W'(1);
  localparam logic [C_BITS_W-1:0]          C_DATA_LAST = C_BITS_W'(G_DATA_WIDTH - 1);
  localparam logic                         C_STOP_LAST = (G_STOP_BIT_NUMBER == 2);
  localparam logic                         C_ODD       = (G_PARITY == 2);
  localparam logic                         C_INVERT    = (G_POLARITY == 0);
  localparam logic                         C_HAS_PAR   = (G_PARITY != 0);
  localparam logic [G_BUFFER_ADDR_WIDTH:0] C_WR_ZERO   = (G_BUFFER_ADDR_WIDTH + 1)'(0);
  localparam logic [G_BUFFER_ADDR_WIDTH:0] C_WR_ONE    = (G_BUFFER_ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STORE  = 3'd5
  } state_t;

  // Expected parity bit for a received word (even, or inverted for odd).
  function automatic logic parity_bit(input logic [G_DATA_WIDTH-1:0] word);
    return (^word) ^ C_ODD;
  endfunction

  // Shift one received bit into the word in the configured bit order.
  function automatic logic [G_DATA_WIDTH-1:0] shift_in(input logic [G_DATA_WIDTH-1:0] word,
                                                       input logic                    bit_v);
    if (G_FIRST_BIT == 0) begin
      return {bit_v, word[G_DATA_WIDTH-1:1]};
    end else begin
      return {word[G_DATA_WIDTH-2:0], bit_v};
    end
  endfunction

  state_t                         state_r, state_nxt;
  logic [C_CNT_W-1:0]             cnt_r, cnt_nxt;
  logic [C_BITS_W-1:0]            bit_cnt_r, bit_cnt_nxt;
  logic                           stop_cnt_r, stop_cnt_nxt;
  logic [G_DATA_WIDTH-1:0]        shift_r, shift_nxt;
  logic                           par_bad_r, par_bad_nxt;
  logic                           frm_bad_r, frm_bad_nxt;
  logic                           start_pend_r, start_pend_nxt;
  logic [G_BUFFER_ADDR_WIDTH:0]   wr_cnt_r, wr_cnt_nxt;
  logic                           parity_err_r, parity_err_nxt;
  logic                           frame_err_r, frame_err_nxt;
  logic                           overflow_r, overflow_nxt;
  logic                           rx_done_r, rx_done_nxt;
  logic [G_DATA_WIDTH-1:0]        rd_data_r;
  logic                           mem_we_s;
  logic [1:0]                     sync_r;
  logic                           rx_prev_r;
  logic                           rx_in_s;
  logic                           rx_sync_s;
  logic                           fall_s;
  logic [G_DATA_WIDTH-1:0]        mem_r [C_DEPTH];

  assign rx_in_s   = i_rx ^ C_INVERT;
  assign rx_sync_s = sync_r[1];
  assign fall_s    = rx_prev_r & ~rx_sync_s;

  // Two-flop synchroniser plus previous-value register for start-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[0], rx_in_s};
      rx_prev_r <= sync_r[1];
    end
  end

  // State register and all frame/buffer bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= C_CNT_ZERO;
      bit_cnt_r    <= C_BITS_ZERO;
      stop_cnt_r   <= 1'b0;
      shift_r      <= {G_DATA_WIDTH{1'b0}};
      par_bad_r    <= 1'b0;
      frm_bad_r    <= 1'b0;
      start_pend_r <= 1'b0;
      wr_cnt_r     <= C_WR_ZERO;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overflow_r   <= 1'b0;
      rx_done_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      cnt_r        <= cnt_nxt;
      bit_cnt_r    <= bit_cnt_nxt;
      stop_cnt_r   <= stop_cnt_nxt;
      shift_r      <= shift_nxt;
      par_bad_r    <= par_bad_nxt;
      frm_bad_r    <= frm_bad_nxt;
      start_pend_r <= start_pend_nxt;
      wr_cnt_r     <= wr_cnt_nxt;
      parity_err_r <= parity_err_nxt;
      frame_err_r  <= frame_err_nxt;
      overflow_r   <= overflow_nxt;
      rx_done_r    <= rx_done_nxt;
    end
  end

  // Next-state, bit timing, frame assembly and buffer/flag updates.
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    bit_cnt_nxt    = bit_cnt_r;
    stop_cnt_nxt   = stop_cnt_r;
    shift_nxt      = shift_r;
    par_bad_nxt    = par_bad_r;
    frm_bad_nxt    = frm_bad_r;
    start_pend_nxt = 1'b0;
    wr_cnt_nxt     = wr_cnt_r;
    parity_err_nxt = parity_err_r;
    frame_err_nxt  = frame_err_r;
    overflow_nxt   = overflow_r;
    mem_we_s       = 1'b0;

    case (state_r)
      S_IDLE: begin
        // A start edge seen during STORE is remembered so back-to-back frames are not lost.
        if (bus.i_en && (fall_s || start_pend_r)) begin
          state_nxt    = S_START;
          cnt_nxt      = C_CNT_ZERO;
          bit_cnt_nxt  = C_BITS_ZERO;
          stop_cnt_nxt = 1'b0;
          par_bad_nxt  = 1'b0;
          frm_bad_nxt  = 1'b0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (!bus.i_en) begin
          state_nxt = S_IDLE;
        end else if (cnt_r == C_HALF_LAST) begin
          cnt_nxt = C_CNT_ZERO;
          if (rx_sync_s) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
          end
        end else begin
          cnt_nxt = cnt_r + C_CNT_ONE;
        end
      end
      S_DATA: begin
        if (!bus.i_en) begin
          state_nxt = S_IDLE;
        end else if (cnt_r == C_BIT_LAST) begin
          cnt_nxt   = C_CNT_ZERO;
          shift_nxt = shift_in(shift_r, rx_sync_s);
          if (bit_cnt_r == C_DATA_LAST) begin
            state_nxt = C_HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt_r + C_BITS_ONE;
          end
        end else begin
          cnt_nxt = cnt_r + C_CNT_ONE;
        end
      end
      S_PARITY: begin
        if (!bus.i_en) begin
          state_nxt = S_IDLE;
        end else if (cnt_r == C_BIT_LAST) begin
          cnt_nxt     = C_CNT_ZERO;
          par_bad_nxt = (rx_sync_s != parity_bit(shift_r));
          state_nxt   = S_STOP;
        end else begin
          cnt_nxt = cnt_r + C_CNT_ONE;
        end
      end
      S_STOP: begin
        if (!bus.i_en) begin
          state_nxt = S_IDLE;
        end else if (cnt_r == C_BIT_LAST) begin
          cnt_nxt     = C_CNT_ZERO;
          frm_bad_nxt = frm_bad_r | ~rx_sync_s;
          if (stop_cnt_r == C_STOP_LAST) begin
            state_nxt = S_STORE;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_r + C_CNT_ONE;
        end
      end
      S_STORE: begin
        state_nxt      = S_IDLE;
        start_pend_nxt = fall_s;
        parity_err_nxt = parity_err_r | par_bad_r;
        frame_err_nxt  = frame_err_r | frm_bad_r;
        // The top count bit doubles as the buffer-full indication.
        if (!wr_cnt_r[G_BUFFER_ADDR_WIDTH]) begin
          mem_we_s   = 1'b1;
          wr_cnt_nxt = wr_cnt_r + C_WR_ONE;
        end else begin
          overflow_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Clear overrides any store in the same cycle; the FSM itself keeps running.
    if (bus.i_clr) begin
      wr_cnt_nxt     = C_WR_ZERO;
      parity_err_nxt = 1'b0;
      frame_err_nxt  = 1'b0;
      overflow_nxt   = 1'b0;
      mem_we_s       = 1'b0;
    end else begin
      mem_we_s = mem_we_s;
    end

    rx_done_nxt = (state_nxt == S_STORE);
  end

  // Capture buffer write port (contents are not reset).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_cnt_r[G_BUFFER_ADDR_WIDTH-1:0]] <= shift_r;
    end
  end

  // Registered read port, independent of the receive FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {G_DATA_WIDTH{1'b0}};
    end else begin
      rd_data_r <= mem_r[bus.i_rd_addr];
    end
  end

  assign bus.o_rd_data    = rd_data_r;
  assign bus.o_wr_cnt     = wr_cnt_r;
  assign bus.o_rx_done    = rx_done_r;
  assign bus.o_parity_err = parity_err_r;
  assign bus.o_frame_err  = frame_err_r;
  assign bus.o_overflow   = overflow_r;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: three instances (defaults, MSB-first with even parity,
// 4-word buffer) driven with hand-built frames and checked against hand-computed values.
module tb_uart_rx_capture;

  localparam int C_BIT = 20000000 / 115200;

  logic clk;
  logic rst_n;
  logic rx_a, rx_b, rx_c;
  int   n_pass, n_total;
  int   done_a, done_b, done_c;

  uart_rx_capture_if #(.G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(8)) bus_a ();
  uart_rx_capture_if #(.G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(8)) bus_b ();
  uart_rx_capture_if #(.G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(2)) bus_c ();

  uart_rx_capture u_dut_a (.clk(clk), .rst_n(rst_n), .i_rx(rx_a), .bus(bus_a));

  uart_rx_capture #(.G_PARITY(1), .G_FIRST_BIT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_b), .bus(bus_b)
  );

  uart_rx_capture #(.G_BUFFER_ADDR_WIDTH(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_c), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which each instance reports a completed frame.
  always @(posedge clk) begin
    if (bus_a.o_rx_done) done_a++;
    if (bus_b.o_rx_done) done_b++;
    if (bus_c.o_rx_done) done_c++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive_line(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bit(input int which, input logic v);
    @(negedge clk);
    drive_line(which, v);
    repeat (C_BIT - 1) @(negedge clk);
  endtask

  // Start, 8 data bits, optional even parity (optionally flipped), stop, one idle bit.
  task automatic send_frame(input int which, input logic [7:0] data, input bit msb_first,
                            input bit with_par, input bit flip_par, input logic stop_val);
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(which, msb_first ? data[7 - i] : data[i]);
    end
    if (with_par) send_bit(which, (^data) ^ flip_par);
    send_bit(which, stop_val);
    send_bit(which, 1'b1);
  endtask

  task automatic rd(input int which, input int addr, output logic [7:0] d);
    @(negedge clk);
    case (which)
      0:       bus_a.i_rd_addr = addr[7:0];
      1:       bus_b.i_rd_addr = addr[7:0];
      default: bus_c.i_rd_addr = addr[1:0];
    endcase
    @(negedge clk);
    case (which)
      0:       d = bus_a.o_rd_data;
      1:       d = bus_b.o_rd_data;
      default: d = bus_c.o_rd_data;
    endcase
  endtask

  task automatic pulse_clr_a();
    @(negedge clk);
    bus_a.i_clr = 1'b1;
    @(negedge clk);
    bus_a.i_clr = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] d;
  int         base;
  bit         found;

  initial begin
    n_pass = 0; n_total = 0;
    done_a = 0; done_b = 0; done_c = 0;
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    bus_a.i_en = 1'b1; bus_a.i_clr = 1'b0; bus_a.i_rd_addr = 8'd0;
    bus_b.i_en = 1'b1; bus_b.i_clr = 1'b0; bus_b.i_rd_addr = 8'd0;
    bus_c.i_en = 1'b1; bus_c.i_clr = 1'b0; bus_c.i_rd_addr = 2'd0;
    repeat (5) @(negedge clk);
    check("rst_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd0);
    check("rst_rd_data", 32'(bus_a.o_rd_data), 32'd0);
    check("rst_flags", {28'd0, bus_a.o_rx_done, bus_a.o_parity_err, bus_a.o_frame_err, bus_a.o_overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Default configuration: three LSB-first frames.
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("a_done_cnt", done_a, 32'd3);
    check("a_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd3);
    rd(0, 0, d); check("a_rd0", 32'(d), 32'hFF);
    rd(0, 1, d); check("a_rd1", 32'(d), 32'h01);
    rd(0, 2, d); check("a_rd2", 32'(d), 32'hA5);
    check("a_flags", {29'd0, bus_a.o_parity_err, bus_a.o_frame_err, bus_a.o_overflow}, 32'd0);

    // MSB-first, even parity: good frame, bad-parity frame, then an asymmetric pattern.
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
    check("b_par_after_good", 32'(bus_b.o_parity_err), 32'd0);
    check("b_wr_cnt1", 32'(bus_b.o_wr_cnt), 32'd1);
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    check("b_par_after_bad", 32'(bus_b.o_parity_err), 32'd1);
    check("b_wr_cnt2", 32'(bus_b.o_wr_cnt), 32'd2);
    send_frame(1, 8'hC5, 1'b1, 1'b1, 1'b0, 1'b1);
    check("b_done_cnt", done_b, 32'd3);
    rd(1, 0, d); check("b_rd0", 32'(d), 32'h3C);
    rd(1, 1, d); check("b_rd1", 32'(d), 32'h3C);
    rd(1, 2, d); check("b_rd2_msb_first", 32'(d), 32'hC5);
    check("b_frame_err", 32'(bus_b.o_frame_err), 32'd0);

    // Stop bit driven low: word still stored, frame error sticky until clear.
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a_ferr_set", 32'(bus_a.o_frame_err), 32'd1);
    check("a_ferr_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd4);
    rd(0, 3, d); check("a_rd3_ferr_word", 32'(d), 32'h55);
    pulse_clr_a();
    check("a_clr_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd0);
    check("a_clr_ferr", 32'(bus_a.o_frame_err), 32'd0);

    // 40-cycle glitch is shorter than half a bit and must be rejected.
    base = done_a;
    @(negedge clk); rx_a = 1'b0;
    repeat (40) @(negedge clk);
    rx_a = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_no_done", done_a - base, 32'd0);
    check("glitch_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd0);

    // Four-word buffer overflowed by a fifth frame.
    for (int i = 0; i < 5; i++) begin
      send_frame(2, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("c_wr_cnt_sat", 32'(bus_c.o_wr_cnt), 32'd4);
    check("c_overflow", 32'(bus_c.o_overflow), 32'd1);
    check("c_done_cnt", done_c, 32'd5);
    for (int i = 0; i < 4; i++) begin
      rd(2, i, d);
      check($sformatf("c_rd%0d", i), 32'(d), 32'(8'h10 + i));
    end

    // Enable dropped mid-frame: nothing stored, no done pulse.
    base = done_a;
    fork
      send_frame(0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (C_BIT * 4) @(negedge clk);
        bus_a.i_en = 1'b0;
      end
    join
    bus_a.i_en = 1'b1;
    repeat (20) @(negedge clk);
    check("en_drop_no_done", done_a - base, 32'd0);
    check("en_drop_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd0);

    // Clear during the STORE cycle wins over the write.
    base = done_a;
    fork
      send_frame(0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
          @(negedge clk);
          if (bus_a.o_rx_done) found = 1'b1;
        end
        if (found) begin
          bus_a.i_clr = 1'b1;
          @(negedge clk);
          bus_a.i_clr = 1'b0;
        end
        check("clr_store_done_seen", 32'(found), 32'd1);
      end
    join
    check("clr_store_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd0);
    check("clr_store_done_cnt", done_a - base, 32'd1);

    // Asynchronous reset in the middle of a data bit.
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    rd(0, 0, d); check("pre_rst_rd0", 32'(d), 32'hA5);
    check("pre_rst_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd1);
    base = done_a;
    fork
      send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (C_BIT * 4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rd_data", 32'(bus_a.o_rd_data), 32'd0);
        check("mid_rst_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd0);
        check("mid_rst_flags", {28'd0, bus_a.o_rx_done, bus_a.o_parity_err, bus_a.o_frame_err, bus_a.o_overflow}, 32'd0);
        check("mid_rst_c_overflow", 32'(bus_c.o_overflow), 32'd0);
        check("mid_rst_b_parity", 32'(bus_b.o_parity_err), 32'd0);
      end
    join
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_no_done", done_a - base, 32'd0);
    check("post_rst_wr_cnt", 32'(bus_a.o_wr_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
UART receive engine with capture buffer. It is the reader end of the testbench UART link: it deserialises frames produced by the checker's TX path (TX_START) or by a DUT, and stores each received word in an internal buffer. The testbench sequencer reads the buffer back for RX_READ comparisons. It sits inside the UART checker wrapper, one instance per UART alias.

Parameters:
G_CLOCK_FREQ, 20000000, clk frequency in Hz
G_BAUDRATE, 115200, line rate in baud; C_BIT_PERIOD = G_CLOCK_FREQ/G_BAUDRATE (truncated, 173 at defaults), C_HALF_PERIOD = C_BIT_PERIOD/2
G_DATA_WIDTH, 8, data bits per frame (5..9)
G_PARITY, 0, 0 = none, 1 = even, 2 = odd
G_STOP_BIT_NUMBER, 1, stop bits (1 or 2)
G_FIRST_BIT, 0, 0 = LSB first, 1 = MSB first
G_POLARITY, 1, 1 = line idles high; 0 = inverted line (i_rx XORed with 1 before use)
G_BUFFER_ADDR_WIDTH, 8, buffer depth = 2**G_BUFFER_ADDR_WIDTH words

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_rx  in  1  serial line, asynchronous to clk
i_en  in  1  capture enable
i_clr  in  1  one-cycle pulse: flush buffer and clear sticky flags
i_rd_addr  in  G_BUFFER_ADDR_WIDTH  buffer read address
o_rd_data  out  G_DATA_WIDTH  buffer read data, 1-cycle latency
o_wr_cnt  out  G_BUFFER_ADDR_WIDTH+1  number of stored words
o_rx_done  out  1  one-cycle pulse per completed frame
o_parity_err  out  1  sticky parity error
o_frame_err  out  1  sticky stop-bit error
o_overflow  out  1  sticky: frame received while buffer full

Behaviour:
- Reset (async, rst_n = 0): FSM = IDLE, counters = 0, o_rd_data = 0, o_wr_cnt = 0, all flags = 0, synchroniser = idle level. Buffer contents are undefined.
- i_rx passes through a 2-FF synchroniser (after the polarity XOR). All decisions use the synchronised bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, STORE.
- IDLE: while i_en = 1 and a falling edge on the synchronised line is seen -> START, baud counter = 0.
- START: at count C_HALF_PERIOD-1, line still 0 -> DATA with counter reloaded; line 1 -> glitch, back to IDLE, nothing stored.
- DATA: sample at every C_BIT_PERIOD from mid-start. Shift into the word according to G_FIRST_BIT. After G_DATA_WIDTH samples -> PARITY if G_PARITY != 0, else STOP.
- PARITY: one sample, compared with the XOR of the data (inverted for odd). A mismatch sets o_parity_err.
- STOP: G_STOP_BIT_NUMBER samples. Any sample = 0 sets o_frame_err. After the last stop sample -> STORE. The next start edge may arrive immediately after the mid-stop sample.
- STORE (1 cycle): if o_wr_cnt < 2**G_BUFFER_ADDR_WIDTH, write the word at address o_wr_cnt[ADDR-1:0] and increment o_wr_cnt. Otherwise set o_overflow; no write, count saturates. Errored frames are still stored. o_rx_done pulses this cycle. -> IDLE.
- Read port: o_rd_data <= mem[i_rd_addr] every cycle, independent of the FSM. A read of the address being written in the same cycle returns the old data.
- i_clr: o_wr_cnt = 0 and all sticky flags = 0 next cycle. The FSM continues. If i_clr coincides with STORE, i_clr wins: the word is discarded, the count stays 0 and o_rx_done still pulses.
- i_en deasserted mid-frame: FSM aborts to IDLE next cycle. No store, no flags, no o_rx_done.
- Stored flags are not per-word; they are sticky until i_clr or reset.

Test Plan:
- Defaults, loop TX sends 0xFF,0x01,0xA5 -> 3 o_rx_done pulses, o_wr_cnt = 3, reads at addr 0/1/2 return 0xFF/0x01/0xA5 one cycle after the address is applied, all flags 0.
- G_FIRST_BIT = 1 and G_PARITY = 1; send 0x3C with a correct parity bit, then 0x3C with a flipped parity bit -> both stored as 0x3C, o_parity_err rises only after the second frame.
- Drive stop bit = 0 on 0x55 -> 0x55 stored, o_frame_err = 1. Then i_clr -> o_wr_cnt = 0, o_frame_err = 0.
- Low pulse of 40 cycles (< C_HALF_PERIOD = 86) on idle line -> no o_rx_done, o_wr_cnt unchanged.
- G_BUFFER_ADDR_WIDTH = 2; send 5 frames 0x10..0x14 -> o_wr_cnt = 4, addr 0..3 = 0x10..0x13, o_overflow = 1.
- Edge cases:
  - rst_n asserted mid-DATA -> all outputs 0 immediately.
  - i_en dropped mid-frame -> no store.
  - i_clr in the STORE cycle -> o_wr_cnt stays 0.
